// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/bubble control for load-use, EX redirect, sync drain and memory wait
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_sync,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_reg_dst_id,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_bubble,
  output logic        id_ex_stall,
  output logic        id_ex_bubble,
  output logic        ex_mem_stall,
  output logic        mem_wb_bubble,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, DRAIN, SYNC_GO} state_t;
  state_t state, state_nx;
  logic [DW-1:0] drain_cnt, drain_cnt_nx;
  logic [WW-1:0] wait_cnt;
  logic timeout_q;
  logic [31:0] stall_q;
  logic memwait, load_use, drain_act, hold_id, stall_c;
  assign memwait = mem_req && !mem_ready;
  assign load_use = ex_mem_to_reg && ex_reg_dst_id != 5'd0 &&
                    ((id_uses_rs && id_rs == ex_reg_dst_id) || (id_uses_rt && id_rt == ex_reg_dst_id));
  assign drain_act = (state == RUN && id_is_sync) || state == DRAIN;
  // Drain and load-use share the same hold-ID response; drain simply wins the FSM.
  assign hold_id = !ex_redirect && (drain_act || (state == RUN && load_use));
  assign stall_c = memwait || hold_id;
  always_comb begin
    state_nx = state;
    drain_cnt_nx = drain_cnt;
    if (!memwait) begin
      if (ex_redirect) begin
        state_nx = RUN;
        drain_cnt_nx = '0;
      end else if (state == RUN && id_is_sync) begin
        state_nx = DRAIN_CYCLES > 1 ? DRAIN : SYNC_GO;
        drain_cnt_nx = DW'(DRAIN_CYCLES - 1);
      end else if (state == DRAIN) begin
        drain_cnt_nx = drain_cnt - 1'b1;
        state_nx = drain_cnt == DW'(1) ? SYNC_GO : DRAIN;
      end else if (state == SYNC_GO) begin
        state_nx = RUN;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= RUN;
      drain_cnt <= '0;
      wait_cnt <= '0;
      timeout_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state <= state_nx;
      drain_cnt <= drain_cnt_nx;
      wait_cnt <= !memwait ? '0 : wait_cnt == WW'(MEM_TIMEOUT) ? wait_cnt : wait_cnt + 1'b1;
      if (memwait && wait_cnt >= WW'(MEM_TIMEOUT - 1)) timeout_q <= 1'b1;
      if (stall_c) stall_q <= stall_q + 32'd1;
    end
  end
  assign pc_stall      = rst_n && stall_c;
  assign if_id_stall   = rst_n && stall_c;
  assign if_id_bubble  = rst_n && !memwait && ex_redirect;
  assign id_ex_stall   = rst_n && memwait;
  assign id_ex_bubble  = rst_n && !memwait && (ex_redirect || hold_id);
  assign ex_mem_stall  = rst_n && memwait;
  assign mem_wb_bubble = rst_n && memwait;
  assign mem_timeout   = rst_n && timeout_q;
  assign stall_cycles  = rst_n ? stall_q : 32'd0;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table plus multi-cycle sequences, scoreboarded against hazard_ctrl
module tb_hazard_ctrl;
  logic sys_clk = 1'b0;
  logic rst_n, id_uses_rs, id_uses_rt, id_is_sync, ex_mem_to_reg, ex_redirect, mem_req, mem_ready;
  logic [4:0] id_rs, id_rt, ex_reg_dst_id;
  logic pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble, mem_timeout;
  logic [31:0] stall_cycles;
  logic [7:0] obs;
  always #5 sys_clk = ~sys_clk;
  hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_sync(id_is_sync),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst_id(ex_reg_dst_id), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_bubble(if_id_bubble), .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble),
    .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );
  assign obs = {pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble, mem_timeout};
  // {pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble, mem_timeout}
  localparam logic [7:0] NONE = 8'h00, STL = 8'hC8, RDR = 8'h28, MW = 8'hD6, TO = 8'h01;
  typedef struct {
    string n;
    logic r;
    logic [4:0] rs, rt;
    logic urs, urt, sy, ld;
    logic [4:0] dst;
    logic rd, rq, ry;
    logic [7:0] e;
  } vec_t;
  typedef struct {
    string n;
    logic [7:0] o;
    logic [31:0] sc;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[$];
  int checks = 0, failures = 0;
  logic [31:0] scnt = 32'd0;
  function automatic vec_t mk(string n, logic r, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic sy, logic ld, logic [4:0] dst, logic rd, logic rq, logic ry, logic [7:0] e);
    vec_t v;
    v.n = n; v.r = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.sy = sy; v.ld = ld;
    v.dst = dst; v.rd = rd; v.rq = rq; v.ry = ry; v.e = e;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    exp_t x, got;
    rst_n = v.r; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_is_sync = v.sy; ex_mem_to_reg = v.ld; ex_reg_dst_id = v.dst; ex_redirect = v.rd;
    mem_req = v.rq; mem_ready = v.ry;
    x.n = v.n; x.o = v.e; x.sc = v.r ? scnt : 32'd0;
    sb.push_back(x);
    scnt = !v.r ? 32'd0 : scnt + (v.e[7] ? 32'd1 : 32'd0);
    @(negedge sys_clk);
    got = sb.pop_front();
    checks++;
    if (obs !== got.o) begin
      failures++;
      $display("FAIL %s outputs got=%b exp=%b", got.n, obs, got.o);
    end
    checks++;
    if (stall_cycles !== got.sc) begin
      failures++;
      $display("FAIL %s stall_cycles got=%0d exp=%0d", got.n, stall_cycles, got.sc);
    end
    @(posedge sys_clk);
    #1;
  endtask
  initial begin
    tbl.push_back(mk("reset",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("idle",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("lu_rs",        1, 5, 0, 1, 0, 0, 1, 5, 0, 0, 0, STL));
    tbl.push_back(mk("lu_dst0",      1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("lu_rt",        1, 0, 7, 0, 1, 0, 1, 7, 0, 0, 0, STL));
    tbl.push_back(mk("lu_rt_unused", 1, 0, 7, 0, 0, 0, 1, 7, 0, 0, 0, NONE));
    tbl.push_back(mk("lu_not_load",  1, 5, 0, 1, 0, 0, 0, 5, 0, 0, 0, NONE));
    tbl.push_back(mk("redirect",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RDR));
    tbl.push_back(mk("redir_over_lu",1, 5, 0, 1, 0, 0, 1, 5, 1, 0, 0, RDR));
    tbl.push_back(mk("sync_c0",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL));
    tbl.push_back(mk("sync_c1",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL));
    tbl.push_back(mk("sync_c2",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL));
    tbl.push_back(mk("sync_go",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("sync_run",     1, 5, 0, 1, 0, 0, 1, 5, 0, 0, 0, STL));
    tbl.push_back(mk("rd_drain_c0",  1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL));
    tbl.push_back(mk("rd_drain_c1",  1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, RDR));
    tbl.push_back(mk("rd_drain_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    for (int k = 0; k < 4; k++) apply(mk("mw_redir",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, MW));
    apply(mk("mw_release",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, RDR));
    apply(mk("mw_after",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    apply(mk("mwd_c0",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL));
    for (int k = 0; k < 2; k++) apply(mk("mwd_wait", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, MW));
    apply(mk("mwd_c1",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL));
    apply(mk("mwd_c2",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL));
    apply(mk("mwd_go",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, NONE));
    apply(mk("mwd_run",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    for (int k = 0; k < 8; k++) apply(mk("to_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MW));
    apply(mk("to_ready",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, TO));
    apply(mk("to_sticky",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TO));
    apply(mk("to_wait2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MW | TO));
    apply(mk("rst_midwait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE));
    apply(mk("rst_after",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    for (int k = 0; k < 7; k++) apply(mk("wait_clr", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MW));
    apply(mk("wait_clr_end",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    apply(mk("rsd_c0",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STL));
    apply(mk("rsd_rst",     0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, NONE));
    apply(mk("rsd_run",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    apply(mk("rsd_lu",      1, 9, 0, 1, 0, 0, 1, 9, 0, 0, 0, STL));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
